snake_grid_engine: RTL and testbench
====================================

Name: snake_grid_engine

Overview:
- Upstream neighbour of the matrix display driver. It owns the snake body state and produces the registered 16x16 grid bitmap that the driver scans out.
- On each game tick it does the following:
  - advances the head one cell in the requested direction;
  - checks for wall and self collision;
  - grows the snake if the head lands on food;
  - updates the grid incrementally by setting the head bit and clearing the tail bit.
- The body is stored as a circular buffer of (row, col) coordinates.

Parameters:
- MAX_LEN, 64, capacity of the body buffer in segments. Must be a power of two, 4..256.
- PTR_W, $clog2(MAX_LEN), width of the buffer pointers and the length counter (counter is PTR_W+1 bits).

Ports:
- clk  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- tick  input  1  one-cycle game-step strobe
- restart  input  1  synchronous re-initialise; takes priority over tick
- dir  input  2  requested heading: 00 up (row-1), 01 right (col+1), 10 down (row+1), 11 left (col-1)
- food_valid  input  1  food present at food_row/food_col
- food_row  input  4  food row
- food_col  input  4  food column
- grid  output  [15:0][15:0]  registered bitmap, indexed grid[row][col]; snake bits OR food bit
- head_row  output  4  current head row
- head_col  output  4  current head column
- length  output  PTR_W+1  current segment count
- ate  output  1  one-cycle pulse when food is consumed
- busy  output  1  high while a step is in progress
- game_over  output  1  sticky collision flag

Behaviour:
- Reset (async, reset_n low) and restart (sync) put the block in the same initial state:
  - body = head (8,8), then (8,7), then tail (8,6); length = 3; heading = right.
  - grid rows 8, cols 6..8 set; all other snake bits clear.
  - ate = 0, busy = 0, game_over = 0, state = IDLE.
  - The food bit appears in grid from the first clock edge after reset or restart.
- State machine: IDLE -> CALC -> CHECK -> UPDATE -> IDLE, with DEAD as a terminal state.
- IDLE:
  - tick = 1 and game_over = 0 -> go to CALC; busy = 1 from the next cycle.
  - tick while busy or in DEAD is ignored (not queued).
- CALC:
  - Sample dir. If dir is the exact reverse of the current heading, keep the current heading; otherwise adopt dir.
  - Compute next head with 4-bit arithmetic and flag any edge crossing (row 0 going up, row 15 going down, col 0 going left, col 15 going right).
- CHECK:
  - eat = food_valid AND (next head == food).
  - grow = eat AND (length < MAX_LEN).
  - Self-hit = snake bit at next head is set, unless (next head == tail AND grow = 0), since the tail vacates that cell this step.
  - Self-hit or edge crossing (without WRAP_WALLS_EN) -> DEAD; game_over = 1 next cycle; no body or grid change.
- UPDATE:
  - Write next head into the buffer at head_ptr+1 (mod MAX_LEN) and set its grid bit.
  - If grow = 0: clear the tail grid bit and advance tail_ptr. If the new head equals the old tail, the set wins.
  - If grow = 1: length increments.
  - ate pulses for exactly one cycle whenever eat = 1, including at MAX_LEN, where length saturates and the tail still moves.
  - head_row/head_col update here.
- Timing:
  - Tick at cycle T -> CALC at T+1, CHECK at T+2, UPDATE at T+3.
  - New grid, head, length and ate are all visible at T+4, and busy drops at T+4.
  - Minimum tick spacing is 4 cycles.
- DEAD:
  - grid, head and length are frozen; busy = 0.
  - Only restart or reset exits, returning to IDLE with the initial state.
- Restart mid-step (any state) aborts the step; no partial update is applied.
- grid output = registered (snake_grid OR one-hot food mask when food_valid), updated every cycle.

Optional Feature:
- WRAP_WALLS_EN defined:
  - An edge crossing wraps modulo 16, e.g. head (8,15) moving right -> (8,0).
  - Only self-hit sets game_over.
- Not defined: an edge crossing sets game_over and the snake freezes at its pre-step position.

Test Plan:
- Reset, then tick with dir = 01, food_valid = 0:
  - At T+4: head = (8,9), grid[8][9] = 1, grid[8][6] = 0, length = 3, ate = 0.
- Food at (8,9), tick with dir = 01:
  - length = 4, ate high for exactly one cycle at T+4, grid[8][6] still 1.
- Heading right, tick with dir = 11 (reverse):
  - Head moves right to (8,9); the reverse request is ignored.
- Ticks with dir = 00 repeated until the head is at row 0, then one more tick:
  - Without macro: game_over = 1 and the grid is unchanged.
  - With WRAP_WALLS_EN: head moves to row 15 and game_over stays 0.
- Grow to length 5, then steer the head into its own body:
  - game_over = 1, busy = 0, later ticks ignored.
  - restart restores length = 3 and head = (8,8).
- Assert reset_n low during UPDATE:
  - All outputs return to initial values immediately (asynchronously).
  - A tick in the first cycle after release is accepted.

Source files
------------

// File: rtl/snake_grid_engine.sv
// Snake body/grid engine: moves head, checks walls/self, grows on food, drives a registered 16x16 bitmap.
// Latency: tick at T -> CALC T+1, CHECK T+2, UPDATE T+3; new grid/head/length/ate visible at T+4.
// Backpressure: none; ticks while busy or dead are dropped, so ticks must be spaced at least 4 cycles apart.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   tick, restart           game-step strobe; synchronous re-initialise (wins over tick)
//   dir                     requested heading: 00 up, 01 right, 10 down, 11 left
//   food_valid/row/col      food location, shown in grid and consumed on contact
//   grid[row][col]          registered snake bitmap OR food bit
//   head_row/head_col       current head cell
//   length                  segment count (PTR_W+1 bits, saturates at MAX_LEN)
//   ate                     one-cycle pulse when food is consumed
//   busy                    high while a step is in progress
//   game_over               sticky collision flag, cleared only by restart/reset
//
// Optional: define WRAP_WALLS_EN to make edge crossings wrap modulo 16 instead of ending the game.

module snake_grid_engine #(
    parameter int MAX_LEN = 64,
    parameter int PTR_W   = $clog2(MAX_LEN)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  tick,
    input  logic                  restart,
    input  logic [1:0]            dir,
    input  logic                  food_valid,
    input  logic [3:0]            food_row,
    input  logic [3:0]            food_col,
    output logic [15:0][15:0]     grid,
    output logic [3:0]            head_row,
    output logic [3:0]            head_col,
    output logic [PTR_W:0]        length,
    output logic                  ate,
    output logic                  busy,
    output logic                  game_over
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC,
        S_CHECK,
        S_UPDATE,
        S_DEAD
    } state_t;

    localparam logic [PTR_W:0] LEN_MAX  = (PTR_W+1)'(MAX_LEN);
    localparam logic [PTR_W:0] LEN_INIT = (PTR_W+1)'(3);

    function automatic logic [15:0][15:0] init_grid();
        logic [15:0][15:0] g;
        g       = '0;
        g[8][6] = 1'b1;
        g[8][7] = 1'b1;
        g[8][8] = 1'b1;
        return g;
    endfunction

    state_t              state, state_nxt;
    logic [1:0]          heading;
    logic [1:0]          hdg_sel;
    logic [3:0]          nxt_row, nxt_col;
    logic [3:0]          calc_row, calc_col;
    logic                grow_q, eat_q;
    logic [PTR_W-1:0]    head_ptr, tail_ptr, head_ptr_inc;
    logic [3:0]          body_row [MAX_LEN];
    logic [3:0]          body_col [MAX_LEN];
    logic [3:0]          tail_row, tail_col;
    logic [15:0][15:0]   snake_grid, snake_grid_nxt;
    logic [15:0][15:0]   food_mask;
    logic                eat, grow, self_hit, collide;
`ifndef WRAP_WALLS_EN
    logic                edge_hit, calc_edge;
`endif

    assign busy      = (state == S_CALC) || (state == S_CHECK) || (state == S_UPDATE);
    assign game_over = (state == S_DEAD);

    assign head_ptr_inc = head_ptr + 1'b1;
    assign tail_row     = body_row[tail_ptr];
    assign tail_col     = body_col[tail_ptr];

    // A request for the exact reverse heading differs from it only in bit 1.
    assign hdg_sel = ((dir ^ heading) == 2'b10) ? heading : dir;

    // Next-head arithmetic is 4-bit, so it wraps on its own; the edge flag records the crossing.
    always_comb begin
        calc_row  = head_row;
        calc_col  = head_col;
`ifndef WRAP_WALLS_EN
        calc_edge = 1'b0;
`endif
        case (hdg_sel)
            2'b00: begin
                calc_row = head_row - 4'd1;
`ifndef WRAP_WALLS_EN
                calc_edge = (head_row == 4'd0);
`endif
            end
            2'b01: begin
                calc_col = head_col + 4'd1;
`ifndef WRAP_WALLS_EN
                calc_edge = (head_col == 4'd15);
`endif
            end
            2'b10: begin
                calc_row = head_row + 4'd1;
`ifndef WRAP_WALLS_EN
                calc_edge = (head_row == 4'd15);
`endif
            end
            default: begin
                calc_col = head_col - 4'd1;
`ifndef WRAP_WALLS_EN
                calc_edge = (head_col == 4'd0);
`endif
            end
        endcase
    end

    assign eat  = food_valid && (nxt_row == food_row) && (nxt_col == food_col);
    assign grow = eat && (length < LEN_MAX);
    // Moving onto the tail is legal when not growing: the tail leaves that cell in the same step.
    assign self_hit = snake_grid[nxt_row][nxt_col] &&
                      !((nxt_row == tail_row) && (nxt_col == tail_col) && !grow);
`ifdef WRAP_WALLS_EN
    assign collide = self_hit;
`else
    assign collide = self_hit || edge_hit;
`endif

    always_comb begin
        food_mask = '0;
        if (food_valid) begin
            food_mask[food_row][food_col] = 1'b1;
        end
    end

    // Tail clear is applied before head set so the head wins when it lands on the old tail.
    always_comb begin
        snake_grid_nxt = snake_grid;
        if (restart) begin
            snake_grid_nxt = init_grid();
        end else if (state == S_UPDATE) begin
            if (!grow_q) begin
                snake_grid_nxt[tail_row][tail_col] = 1'b0;
            end
            snake_grid_nxt[nxt_row][nxt_col] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        if (restart) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:   if (tick) state_nxt = S_CALC;
                S_CALC:   state_nxt = S_CHECK;
                S_CHECK:  state_nxt = collide ? S_DEAD : S_UPDATE;
                S_UPDATE: state_nxt = S_IDLE;
                S_DEAD:   state_nxt = S_DEAD;
                default:  state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            snake_grid <= init_grid();
            grid       <= init_grid();
            heading    <= 2'b01;
            nxt_row    <= '0;
            nxt_col    <= '0;
`ifndef WRAP_WALLS_EN
            edge_hit   <= 1'b0;
`endif
            grow_q     <= 1'b0;
            eat_q      <= 1'b0;
            head_row   <= 4'd8;
            head_col   <= 4'd8;
            length     <= LEN_INIT;
            ate        <= 1'b0;
            head_ptr   <= PTR_W'(2);
            tail_ptr   <= '0;
            for (int i = 0; i < MAX_LEN; i++) begin
                body_row[i] <= 4'd8;
                body_col[i] <= (i < 3) ? 4'(6 + i) : 4'd0;
            end
        end else begin
            snake_grid <= snake_grid_nxt;
            grid       <= snake_grid_nxt | food_mask;
            ate        <= 1'b0;
            if (restart) begin
                heading  <= 2'b01;
                grow_q   <= 1'b0;
                eat_q    <= 1'b0;
                head_row <= 4'd8;
                head_col <= 4'd8;
                length   <= LEN_INIT;
                head_ptr <= PTR_W'(2);
                tail_ptr <= '0;
                for (int i = 0; i < 3; i++) begin
                    body_row[i] <= 4'd8;
                    body_col[i] <= 4'(6 + i);
                end
            end else begin
                case (state)
                    S_CALC: begin
                        heading  <= hdg_sel;
                        nxt_row  <= calc_row;
                        nxt_col  <= calc_col;
`ifndef WRAP_WALLS_EN
                        edge_hit <= calc_edge;
`endif
                    end
                    S_CHECK: begin
                        grow_q <= grow;
                        eat_q  <= eat;
                    end
                    S_UPDATE: begin
                        body_row[head_ptr_inc] <= nxt_row;
                        body_col[head_ptr_inc] <= nxt_col;
                        head_ptr <= head_ptr_inc;
                        head_row <= nxt_row;
                        head_col <= nxt_col;
                        ate      <= eat_q;
                        if (grow_q) begin
                            length <= length + 1'b1;
                        end else begin
                            tail_ptr <= tail_ptr + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_snake_grid_engine.sv
module tb_snake_grid_engine;

    logic              clk = 1'b0;
    logic              reset_n = 1'b1;
    logic              tick = 1'b0;
    logic              restart = 1'b0;
    logic [1:0]        dir = 2'b01;
    logic              food_valid = 1'b0;
    logic [3:0]        food_row = '0;
    logic [3:0]        food_col = '0;
    logic [15:0][15:0] grid;
    logic [3:0]        head_row, head_col;
    logic [6:0]        length;
    logic              ate, busy, game_over;

    int vectors = 0;
    int miscompares = 0;

    snake_grid_engine dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .tick       (tick),
        .restart    (restart),
        .dir        (dir),
        .food_valid (food_valid),
        .food_row   (food_row),
        .food_col   (food_col),
        .grid       (grid),
        .head_row   (head_row),
        .head_col   (head_col),
        .length     (length),
        .ate        (ate),
        .busy       (busy),
        .game_over  (game_over)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] d;
        logic       fv;
        logic [3:0] fr, fc;
        logic [3:0] hr, hc;
        int         len;
        logic       ate, go;
        logic [3:0] ar, ac;
        logic       av;
        logic [3:0] br, bc;
        logic       bv;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_grid(input string nm, input logic [15:0][15:0] act, input logic [15:0][15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0][15:0] grid_of3(input logic [3:0] r0, c0, r1, c1, r2, c2);
        logic [15:0][15:0] g;
        g = '0;
        g[r0][c0] = 1'b1;
        g[r1][c1] = 1'b1;
        g[r2][c2] = 1'b1;
        return g;
    endfunction

    // Called at posedge+1; returns at posedge+1 of cycle T+1.
    task automatic start_tick(input logic [1:0] d);
        dir  = d;
        tick = 1'b1;
        @(posedge clk);
        #1;
        tick = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_restart();
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
    endtask

    logic [15:0][15:0] g_init;
    logic [15:0][15:0] g_exp;
    logic              prev_go;
    logic              busy_t1;

    initial begin
        g_init = grid_of3(4'd8, 4'd6, 4'd8, 4'd7, 4'd8, 4'd8);

        //            rst d     fv  fr  fc   hr  hc  len ate go  ar  ac  av   br  bc  bv
        vecs[0]  = '{1'b0, 2'b01, 1'b0, 4'd0, 4'd0,  4'd8, 4'd9,  3, 1'b0, 1'b0, 4'd8, 4'd9,  1'b1, 4'd8, 4'd6,  1'b0};
        vecs[1]  = '{1'b0, 2'b01, 1'b1, 4'd8, 4'd10, 4'd8, 4'd10, 4, 1'b1, 1'b0, 4'd8, 4'd10, 1'b1, 4'd8, 4'd7,  1'b1};
        vecs[2]  = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0,  4'd8, 4'd11, 4, 1'b0, 1'b0, 4'd8, 4'd11, 1'b1, 4'd8, 4'd7,  1'b0};
        vecs[3]  = '{1'b0, 2'b10, 1'b0, 4'd0, 4'd0,  4'd9, 4'd11, 4, 1'b0, 1'b0, 4'd9, 4'd11, 1'b1, 4'd8, 4'd8,  1'b0};
        vecs[4]  = '{1'b0, 2'b00, 1'b0, 4'd0, 4'd0,  4'd10,4'd11, 4, 1'b0, 1'b0, 4'd10,4'd11, 1'b1, 4'd8, 4'd9,  1'b0};
        vecs[5]  = '{1'b0, 2'b11, 1'b1, 4'd10,4'd10, 4'd10,4'd10, 5, 1'b1, 1'b0, 4'd10,4'd10, 1'b1, 4'd8, 4'd10, 1'b1};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 4'd0, 4'd0,  4'd9, 4'd10, 5, 1'b0, 1'b0, 4'd9, 4'd10, 1'b1, 4'd8, 4'd10, 1'b0};
        vecs[7]  = '{1'b0, 2'b01, 1'b0, 4'd0, 4'd0,  4'd9, 4'd10, 5, 1'b0, 1'b1, 4'd9, 4'd11, 1'b1, 4'd8, 4'd11, 1'b1};
        vecs[8]  = '{1'b0, 2'b01, 1'b0, 4'd0, 4'd0,  4'd9, 4'd10, 5, 1'b0, 1'b1, 4'd9, 4'd10, 1'b1, 4'd8, 4'd11, 1'b1};
        vecs[9]  = '{1'b1, 2'b01, 1'b1, 4'd8, 4'd9,  4'd8, 4'd9,  4, 1'b1, 1'b0, 4'd8, 4'd9,  1'b1, 4'd8, 4'd6,  1'b1};
        vecs[10] = '{1'b0, 2'b10, 1'b0, 4'd0, 4'd0,  4'd9, 4'd9,  4, 1'b0, 1'b0, 4'd9, 4'd9,  1'b1, 4'd8, 4'd6,  1'b0};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 4'd0, 4'd0,  4'd9, 4'd8,  4, 1'b0, 1'b0, 4'd9, 4'd8,  1'b1, 4'd8, 4'd7,  1'b0};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 4'd0, 4'd0,  4'd8, 4'd8,  4, 1'b0, 1'b0, 4'd8, 4'd8,  1'b1, 4'd8, 4'd9,  1'b1};
        vecs[13] = '{1'b0, 2'b01, 1'b1, 4'd8, 4'd9,  4'd8, 4'd8,  4, 1'b0, 1'b1, 4'd8, 4'd9,  1'b1, 4'd8, 4'd8,  1'b1};

        // Reset state
        #1 reset_n = 1'b0;
        #1;
        chk("rst_head_row", 32'(head_row), 32'd8);
        chk("rst_head_col", 32'(head_col), 32'd8);
        chk("rst_length", 32'(length), 32'd3);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_game_over", 32'(game_over), 32'd0);
        chk("rst_ate", 32'(ate), 32'd0);
        chk_grid("rst_grid", grid, g_init);
        @(posedge clk);
        #1 reset_n = 1'b1;

        // Food bit follows food_valid one edge later
        food_valid = 1'b1; food_row = 4'd3; food_col = 4'd3;
        wait_cycles(1);
        g_exp = g_init;
        g_exp[3][3] = 1'b1;
        chk_grid("food_shown", grid, g_exp);
        food_valid = 1'b0;
        wait_cycles(1);
        chk_grid("food_gone", grid, g_init);

        // Table of game steps
        prev_go = 1'b0;
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].rst) begin
                do_restart();
                prev_go = 1'b0;
            end
            food_valid = vecs[i].fv;
            food_row   = vecs[i].fr;
            food_col   = vecs[i].fc;
            start_tick(vecs[i].d);
            busy_t1 = busy;
            chk($sformatf("v%0d_busy_t1", i), 32'(busy_t1), 32'(!prev_go));
            wait_cycles(3);
            chk($sformatf("v%0d_head_row", i), 32'(head_row), 32'(vecs[i].hr));
            chk($sformatf("v%0d_head_col", i), 32'(head_col), 32'(vecs[i].hc));
            chk($sformatf("v%0d_length", i), 32'(length), 32'(vecs[i].len));
            chk($sformatf("v%0d_ate", i), 32'(ate), 32'(vecs[i].ate));
            chk($sformatf("v%0d_game_over", i), 32'(game_over), 32'(vecs[i].go));
            chk($sformatf("v%0d_busy_t4", i), 32'(busy), 32'd0);
            chk($sformatf("v%0d_grid_a", i), 32'(grid[vecs[i].ar][vecs[i].ac]), 32'(vecs[i].av));
            chk($sformatf("v%0d_grid_b", i), 32'(grid[vecs[i].br][vecs[i].bc]), 32'(vecs[i].bv));
            food_valid = 1'b0;
            wait_cycles(1);
            chk($sformatf("v%0d_ate_t5", i), 32'(ate), 32'd0);
            prev_go = vecs[i].go;
        end

        // Dead state: restart restores the initial snake
        do_restart();
        chk("restart_head_row", 32'(head_row), 32'd8);
        chk("restart_head_col", 32'(head_col), 32'd8);
        chk("restart_length", 32'(length), 32'd3);
        chk("restart_game_over", 32'(game_over), 32'd0);
        chk_grid("restart_grid", grid, g_init);

        // Walk up to row 0, then one more step across the wall
        for (int s = 0; s < 8; s++) begin
            start_tick(2'b00);
            wait_cycles(3);
            chk($sformatf("up%0d_head_row", s), 32'(head_row), 32'(7 - s));
            chk($sformatf("up%0d_game_over", s), 32'(game_over), 32'd0);
        end
        start_tick(2'b00);
        wait_cycles(3);
`ifdef WRAP_WALLS_EN
        chk("wall_head_row", 32'(head_row), 32'd15);
        chk("wall_game_over", 32'(game_over), 32'd0);
        chk_grid("wall_grid", grid, grid_of3(4'd15, 4'd8, 4'd0, 4'd8, 4'd1, 4'd8));
`else
        chk("wall_head_row", 32'(head_row), 32'd0);
        chk("wall_game_over", 32'(game_over), 32'd1);
        chk_grid("wall_grid", grid, grid_of3(4'd0, 4'd8, 4'd1, 4'd8, 4'd2, 4'd8));
`endif

        // Restart in the middle of a step aborts it
        do_restart();
        start_tick(2'b01);
        wait_cycles(1);
        restart = 1'b1;
        wait_cycles(1);
        restart = 1'b0;
        chk("abort_head_col", 32'(head_col), 32'd8);
        chk("abort_busy", 32'(busy), 32'd0);
        wait_cycles(2);
        chk("abort_head_col_late", 32'(head_col), 32'd8);
        chk_grid("abort_grid", grid, g_init);

        // Asynchronous reset during UPDATE
        start_tick(2'b10);
        wait_cycles(2);
        chk("pre_arst_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_head_row", 32'(head_row), 32'd8);
        chk("arst_head_col", 32'(head_col), 32'd8);
        chk("arst_length", 32'(length), 32'd3);
        chk("arst_busy", 32'(busy), 32'd0);
        chk_grid("arst_grid", grid, g_init);
        @(posedge clk);
        #1 reset_n = 1'b1;
        start_tick(2'b01);
        wait_cycles(3);
        chk("post_arst_head_col", 32'(head_col), 32'd9);
        chk("post_arst_head_row", 32'(head_row), 32'd8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
